// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - mnemonic kind codes, opcode/funct constants and field packers for the instruction encoder
package instr_pkg;

  typedef enum logic [4:0] {
    K_ADDU  = 5'd0,  K_SUBU = 5'd1,  K_AND   = 5'd2,  K_OR  = 5'd3,
    K_SLTU  = 5'd4,  K_MULTU = 5'd5, K_MFHI  = 5'd6,  K_MFLO = 5'd7,
    K_LW    = 5'd8,  K_SW   = 5'd9,  K_BEQ   = 5'd10, K_BLTZ = 5'd11,
    K_ADDIU = 5'd12, K_J    = 5'd13, K_JAL   = 5'd14, K_LUI = 5'd15,
    K_ORI   = 5'd16
  } kind_e;

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE} state_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - encode-request handshake bundle
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_kind;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [25:0] imm;

  modport master (output req_valid, req_kind, rs, rt, rd, imm, input req_ready);
  modport slave  (input req_valid, req_kind, rs, rt, rd, imm, output req_ready);
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational kind+fields to 32-bit word packer with illegal-kind flag
module instr_pack
  import instr_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Fields a mnemonic does not use are passed as literal zeros, never from the inputs.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_ADDU:  word = r_word(rs, rt, rd, FN_ADDU);
      K_SUBU:  word = r_word(rs, rt, rd, FN_SUBU);
      K_AND:   word = r_word(rs, rt, rd, FN_AND);
      K_OR:    word = r_word(rs, rt, rd, FN_OR);
      K_SLTU:  word = r_word(rs, rt, rd, FN_SLTU);
      K_MULTU: word = r_word(rs, rt, 5'd0, FN_MULTU);
      K_MFHI:  word = r_word(5'd0, 5'd0, rd, FN_MFHI);
      K_MFLO:  word = r_word(5'd0, 5'd0, rd, FN_MFLO);
      K_LW:    word = i_word(OP_LW, rs, rt, imm[15:0]);
      K_SW:    word = i_word(OP_SW, rs, rt, imm[15:0]);
      K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm[15:0]);
      K_BLTZ:  word = i_word(OP_REGIMM, rs, 5'd0, imm[15:0]);
      K_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
      K_J:     word = {OP_J, imm};
      K_JAL:   word = {OP_JAL, imm};
      K_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
      K_ORI:   word = i_word(OP_ORI, rs, rt, imm[15:0]);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes requests into MIPS words and writes them to sequential instruction-memory addresses
module instr_encoder
  import instr_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  req,
  input  logic            base_load,
  input  logic [AW-1:0]   base_addr,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [31:0]     imem_wdata,
  output logic [AW:0]     wr_count,
  output logic            full,
  output logic            err
);

  localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

  state_e      state;
  logic        armed;
  logic [4:0]  kind_q, rs_q, rt_q, rd_q;
  logic [25:0] imm_q;
  logic [31:0] word;
  logic        illegal;
  logic        take;

  // armed keeps ready low throughout reset and lets it rise on the first edge after release.
  assign req.req_ready = armed && (state == S_IDLE) && !full && !base_load;
  assign take          = req.req_valid && req.req_ready;

  instr_pack u_pack (
    .kind    (kind_q),
    .rs      (rs_q),
    .rt      (rt_q),
    .rd      (rd_q),
    .imm     (imm_q),
    .word    (word),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      kind_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      wr_count   <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (base_load) begin
            imem_addr <= base_addr;
            wr_count  <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
          end else if (take) begin
            kind_q <= req.req_kind;
            rs_q   <= req.rs;
            rt_q   <= req.rt;
            rd_q   <= req.rd;
            imm_q  <= req.imm;
            state  <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (illegal) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            imem_wdata <= word;
            imem_we    <= 1'b1;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          imem_addr <= imem_addr + 1'b1;
          wr_count  <= wr_count + 1'b1;
          full      <= (wr_count + 1'b1) == CAPACITY;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with a 4-word pointer space
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int AW = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   wr_count;
  logic          full;
  logic          err;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  instr_encoder_if req_bus ();

  instr_encoder #(.AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_bus),
    .base_load  (base_load),
    .base_addr  (base_addr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .wr_count   (wr_count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (imem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write addr=%0d data=%h required no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data || cyc !== e.cyc)
          $display("FAIL write got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                   imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
        else
          passes++;
      end
    end
  end

  task automatic send(input logic [4:0] kind, input logic [4:0] rs_v, input logic [4:0] rt_v,
                      input logic [4:0] rd_v, input logic [25:0] imm_v, input bit expect_write,
                      input logic [AW-1:0] addr, input logic [31:0] word);
    int n = 0;
    @(negedge clk);
    while (req_bus.req_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      $display("FAIL send_timeout kind=%0d req_ready=%b required 1", kind, req_bus.req_ready);
      return;
    end
    req_bus.req_valid = 1'b1;
    req_bus.req_kind  = kind;
    req_bus.rs        = rs_v;
    req_bus.rt        = rt_v;
    req_bus.rd        = rd_v;
    req_bus.imm       = imm_v;
    if (expect_write) sb.push_back('{addr, word, cyc + 2});
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic load_base(input logic [AW-1:0] a);
    @(negedge clk);
    base_load = 1'b1;
    base_addr = a;
    @(posedge clk);
    #1 base_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_bus.req_ready !== 1'b0) $display("FAIL rst_ready got=%b required 0", req_bus.req_ready); else passes++;
    checks++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0)
      $display("FAIL rst_imem got we=%b addr=%0d data=%h required 0/0/0", imem_we, imem_addr, imem_wdata); else passes++;
    checks++; if (wr_count !== '0 || full !== 1'b0 || err !== 1'b0)
      $display("FAIL rst_status got cnt=%0d full=%b err=%b required 0/0/0", wr_count, full, err); else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_bus.req_ready !== 1'b1) $display("FAIL rst_release_ready got=%b required 1", req_bus.req_ready); else passes++;
  endtask

  task automatic test_rtype();
    send(K_ADDU,  5'd1, 5'd2, 5'd3,  26'h3FF_FFFF, 1, 2'd0, 32'h0022_1821);
    send(K_SUBU,  5'd4, 5'd5, 5'd6,  26'h0,        1, 2'd1, 32'h0085_3023);
    send(K_MULTU, 5'd1, 5'd2, 5'd31, 26'h155_5555, 1, 2'd2, 32'h0022_0019);
    send(K_SLTU,  5'd2, 5'd3, 5'd4,  26'h0,        1, 2'd3, 32'h0043_202B);
    drain("rtype");
    checks++; if (wr_count !== 3'd4 || full !== 1'b1)
      $display("FAIL rtype_count got cnt=%0d full=%b required 4/1", wr_count, full); else passes++;
  endtask

  task automatic test_itype();
    load_base(2'd0);
    send(K_LW,   5'd29, 5'd8, 5'd17, 26'h000_0004, 1, 2'd0, 32'h8FA8_0004);
    send(K_LUI,  5'd7,  5'd1, 5'd9,  26'h000_1234, 1, 2'd1, 32'h3C01_1234);
    send(K_BLTZ, 5'd3,  5'd9, 5'd9,  26'h000_FFFC, 1, 2'd2, 32'h0460_FFFC);
    send(K_ORI,  5'd2,  5'd3, 5'd30, 26'h3FF_0055, 1, 2'd3, 32'h3443_0055);
    drain("itype");
    checks++; if (wr_count !== 3'd4) $display("FAIL itype_count got=%0d required 4", wr_count); else passes++;
  endtask

  task automatic test_illegal();
    load_base(2'd0);
    send(K_JAL, 5'd5, 5'd6, 5'd7, 26'h010_0000, 1, 2'd0, 32'h0C10_0000);
    send(5'd20, 5'd1, 5'd2, 5'd3, 26'h0, 0, 2'd0, 32'h0);
    drain("illegal");
    checks++; if (err !== 1'b1) $display("FAIL illegal_err got=%b required 1", err); else passes++;
    checks++; if (wr_count !== 3'd1 || imem_addr !== 2'd1)
      $display("FAIL illegal_ptr got cnt=%0d addr=%0d required 1/1", wr_count, imem_addr); else passes++;
    send(K_ADDU, 5'd1, 5'd2, 5'd3, 26'h0, 1, 2'd1, 32'h0022_1821);
    drain("after_illegal");
    checks++; if (err !== 1'b1) $display("FAIL err_sticky got=%b required 1", err); else passes++;
    load_base(2'd0);
    @(negedge clk);
    checks++; if (err !== 1'b0) $display("FAIL err_clear got=%b required 0", err); else passes++;
  endtask

  task automatic test_full();
    bit seen_ready = 0;
    load_base(2'd3);
    send(K_SW,    5'd2,  5'd3,  5'd1, 26'h000_0010, 1, 2'd3, 32'hAC43_0010);
    send(K_BEQ,   5'd1,  5'd2,  5'd8, 26'h000_FFFF, 1, 2'd0, 32'h1022_FFFF);
    send(K_ADDIU, 5'd29, 5'd29, 5'd0, 26'h000_FFF8, 1, 2'd1, 32'h27BD_FFF8);
    send(K_MFLO,  5'd5,  5'd6,  5'd7, 26'h0,        1, 2'd2, 32'h0000_3812);
    drain("full");
    checks++; if (wr_count !== 3'd4 || full !== 1'b1 || req_bus.req_ready !== 1'b0)
      $display("FAIL full_state got cnt=%0d full=%b ready=%b required 4/1/0", wr_count, full, req_bus.req_ready); else passes++;
    req_bus.req_valid = 1'b1;
    req_bus.req_kind  = K_ADDU;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_bus.req_ready !== 1'b0) seen_ready = 1;
    end
    req_bus.req_valid = 1'b0;
    drain("full_blocked");
    checks++; if (seen_ready) $display("FAIL full_blocks ready rose while full, required 0"); else passes++;
  endtask

  task automatic test_load_precedence();
    load_base(2'd0);
    @(negedge clk);
    base_load         = 1'b1;
    base_addr         = 2'd2;
    req_bus.req_valid = 1'b1;
    req_bus.req_kind  = K_ADDU;
    #1;
    checks++; if (req_bus.req_ready !== 1'b0) $display("FAIL load_prec_ready got=%b required 0", req_bus.req_ready); else passes++;
    @(posedge clk);
    #1;
    base_load         = 1'b0;
    req_bus.req_valid = 1'b0;
    drain("load_prec");
    checks++; if (imem_addr !== 2'd2 || wr_count !== 3'd0)
      $display("FAIL load_prec_ptr got addr=%0d cnt=%0d required 2/0", imem_addr, wr_count); else passes++;
  endtask

  task automatic test_reset_in_write();
    int n = 0;
    send(K_ADDU, 5'd1, 5'd2, 5'd3, 26'h0, 1, 2'd2, 32'h0022_1821);
    while (imem_we !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (imem_we !== 1'b1) $display("FAIL rw_reach_write got we=%b required 1", imem_we); else passes++;
    #2 reset = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0) $display("FAIL rw_we got=%b required 0", imem_we); else passes++;
    checks++; if (imem_addr !== '0 || imem_wdata !== '0 || wr_count !== '0 || full !== 1'b0 || err !== 1'b0)
      $display("FAIL rw_outputs got addr=%0d data=%h cnt=%0d full=%b err=%b required all 0",
               imem_addr, imem_wdata, wr_count, full, err); else passes++;
    checks++; if (req_bus.req_ready !== 1'b0) $display("FAIL rw_ready_in_reset got=%b required 0", req_bus.req_ready); else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_bus.req_ready !== 1'b1) $display("FAIL rw_ready_after got=%b required 1", req_bus.req_ready); else passes++;
    sb.delete();
    send(K_J, 5'd31, 5'd31, 5'd31, 26'h3FF_FFFF, 1, 2'd0, 32'h0BFF_FFFF);
    drain("after_reset");
  endtask

  initial begin
    reset             = 1'b1;
    base_load         = 1'b0;
    base_addr         = '0;
    req_bus.req_valid = 1'b0;
    req_bus.req_kind  = '0;
    req_bus.rs        = '0;
    req_bus.rt        = '0;
    req_bus.rd        = '0;
    req_bus.imm       = '0;
    test_reset();
    test_rtype();
    test_itype();
    test_illegal();
    test_full();
    test_load_precedence();
    test_reset_in_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
